prv32_mem_arbiter: RTL and testbench

Two-master round-robin arbiter sharing one picorv32-native memory port (valid/ready/addr/wdata/wstrb/rdata) between two picorv32 cores. Sits between the cores' memory interfaces and a single ROM/RAM slave. Holds the grant until the slave completes the access, then alternates fairly. Counts completed transfers per master for formal and bench checks.

---
 rtl/prv32_mem_arbiter_if.sv | 59 +++++
 rtl/prv32_mem_arbiter.sv | 122 ++++++++++++
 tb/tb_prv32_mem_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/prv32_mem_arbiter_if.sv
// Bundle of the two picorv32 master ports, the shared memory port, grants and counters.
// Latency: none, signal bundle only.
// Backpressure: carried by the valid/ready pairs; a master holds valid until its ready.
//
// modport master : the arbiter's view; it sinks core requests and drives the memory port.
// modport slave  : the surrounding system's view; cores and memory drive, arbiter outputs observed.
interface prv32_mem_arbiter_if #(
    parameter int CNT_WIDTH = 32
);
    // Core A
    logic                 a_valid;
    logic                 a_instr;
    logic [31:0]          a_addr;
    logic [31:0]          a_wdata;
    logic [3:0]           a_wstrb;
    logic                 a_ready;
    logic [31:0]          a_rdata;
    // Core B
    logic                 b_valid;
    logic                 b_instr;
    logic [31:0]          b_addr;
    logic [31:0]          b_wdata;
    logic [3:0]           b_wstrb;
    logic                 b_ready;
    logic [31:0]          b_rdata;
    // Shared memory port
    logic                 mem_valid;
    logic                 mem_instr;
    logic [31:0]          mem_addr;
    logic [31:0]          mem_wdata;
    logic [3:0]           mem_wstrb;
    logic                 mem_ready;
    logic [31:0]          mem_rdata;
    // Status
    logic                 grant_a;
    logic                 grant_b;
    logic [CNT_WIDTH-1:0] cnt_a;
    logic [CNT_WIDTH-1:0] cnt_b;

    modport master (
        input  a_valid, a_instr, a_addr, a_wdata, a_wstrb,
        output a_ready, a_rdata,
        input  b_valid, b_instr, b_addr, b_wdata, b_wstrb,
        output b_ready, b_rdata,
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata,
        output grant_a, grant_b, cnt_a, cnt_b
    );

    modport slave (
        output a_valid, a_instr, a_addr, a_wdata, a_wstrb,
        input  a_ready, a_rdata,
        output b_valid, b_instr, b_addr, b_wdata, b_wstrb,
        input  b_ready, b_rdata,
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata,
        input  grant_a, grant_b, cnt_a, cnt_b
    );
endinterface

// File: rtl/prv32_mem_arbiter.sv
// Two-master round-robin arbiter onto one picorv32-native memory port, with per-master transfer counters.
// Latency: request seen in IDLE -> mem_valid next cycle; ready/rdata returned combinationally in the same cycle as mem_ready.
// Backpressure: grant held until mem_ready completes the access; the ungranted master's request waits, never dropped.
//
// Ports: clock, reset (synchronous, active-high); bus = prv32_mem_arbiter_if.master
//        (core A/B request+response, shared mem request+response, grant_a/grant_b, cnt_a/cnt_b).
module prv32_mem_arbiter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    prv32_mem_arbiter_if.master      bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GNT_A = 2'd1,
        S_GNT_B = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t               r_state;
    logic                 r_grant_a;
    logic                 r_grant_b;
    logic                 r_last_b;     // 1: B was served last, so A wins the next tie
    logic [CNT_WIDTH-1:0] r_cnt_a;
    logic [CNT_WIDTH-1:0] r_cnt_b;

    // Forward the granted master straight through so the slave sees the request
    // in the grant cycle and the response reaches the core with no extra delay.
    always_comb begin
        bus.mem_valid = 1'b0;
        bus.mem_instr = 1'b0;
        bus.mem_addr  = 32'h0;
        bus.mem_wdata = 32'h0;
        bus.mem_wstrb = 4'h0;
        bus.a_ready   = 1'b0;
        bus.b_ready   = 1'b0;
        case (r_state)
            S_GNT_A: begin
                bus.mem_valid = bus.a_valid;
                bus.mem_instr = bus.a_instr;
                bus.mem_addr  = bus.a_addr;
                bus.mem_wdata = bus.a_wdata;
                bus.mem_wstrb = bus.a_wstrb;
                bus.a_ready   = bus.mem_ready & bus.a_valid;
            end
            S_GNT_B: begin
                bus.mem_valid = bus.b_valid;
                bus.mem_instr = bus.b_instr;
                bus.mem_addr  = bus.b_addr;
                bus.mem_wdata = bus.b_wdata;
                bus.mem_wstrb = bus.b_wstrb;
                bus.b_ready   = bus.mem_ready & bus.b_valid;
            end
            default: ;
        endcase
    end

    assign bus.a_rdata = bus.mem_rdata;
    assign bus.b_rdata = bus.mem_rdata;
    assign bus.grant_a = r_grant_a;
    assign bus.grant_b = r_grant_b;
    assign bus.cnt_a   = r_cnt_a;
    assign bus.cnt_b   = r_cnt_b;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_grant_a <= 1'b0;
            r_grant_b <= 1'b0;
            r_last_b  <= 1'b1;
            r_cnt_a   <= '0;
            r_cnt_b   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.a_valid && (!bus.b_valid || r_last_b)) begin
                        r_state   <= S_GNT_A;
                        r_grant_a <= 1'b1;
                    end else if (bus.b_valid) begin
                        r_state   <= S_GNT_B;
                        r_grant_b <= 1'b1;
                    end
                end
                S_GNT_A: begin
                    if (bus.a_valid && bus.mem_ready) begin
                        r_cnt_a  <= r_cnt_a + CNT_ONE;
                        r_last_b <= 1'b0;
                        // Hand over directly when B is waiting: no idle bubble.
                        r_state   <= bus.b_valid ? S_GNT_B : S_IDLE;
                        r_grant_a <= 1'b0;
                        r_grant_b <= bus.b_valid;
                    end else if (!bus.a_valid) begin
                        // Master withdrew mid-access: abandon without counting.
                        r_state   <= S_IDLE;
                        r_grant_a <= 1'b0;
                    end
                end
                S_GNT_B: begin
                    if (bus.b_valid && bus.mem_ready) begin
                        r_cnt_b  <= r_cnt_b + CNT_ONE;
                        r_last_b <= 1'b1;
                        r_state   <= bus.a_valid ? S_GNT_A : S_IDLE;
                        r_grant_b <= 1'b0;
                        r_grant_a <= bus.a_valid;
                    end else if (!bus.b_valid) begin
                        r_state   <= S_IDLE;
                        r_grant_b <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_grant_a <= 1'b0;
                    r_grant_b <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prv32_mem_arbiter.sv
// Bench for prv32_mem_arbiter: directed scenarios, per-cycle comparison against a transaction-level model,
// plus literal expectations for reset, single access, alternation, hold, abort and counter wrap.
// A second instance with 4-bit counters exercises wraparound.
module tb_prv32_mem_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    prv32_mem_arbiter_if #(.CNT_WIDTH(32)) bus ();
    prv32_mem_arbiter_if #(.CNT_WIDTH(4))  bus4 ();

    prv32_mem_arbiter #(.CNT_WIDTH(32)) dut  (.clock(clock), .reset(reset), .bus(bus));
    prv32_mem_arbiter #(.CNT_WIDTH(4))  dut4 (.clock(clock), .reset(reset), .bus(bus4));

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // owner: who currently holds the memory port (0 none, 1 A, 2 B)
    int          m_owner = 0;
    int          m_last  = 2;
    logic [31:0] m_cnt_a = '0;
    logic [31:0] m_cnt_b = '0;

    always @(posedge clock) begin
        if (reset) begin
            m_owner <= 0;
            m_last  <= 2;
            m_cnt_a <= '0;
            m_cnt_b <= '0;
        end else if (m_owner == 0) begin
            if (bus.a_valid && bus.b_valid) m_owner <= (m_last == 1) ? 2 : 1;
            else if (bus.a_valid)           m_owner <= 1;
            else if (bus.b_valid)           m_owner <= 2;
        end else if (m_owner == 1) begin
            if (bus.a_valid && bus.mem_ready) begin
                m_cnt_a <= m_cnt_a + 1;
                m_last  <= 1;
                m_owner <= bus.b_valid ? 2 : 0;
            end else if (!bus.a_valid) m_owner <= 0;
        end else begin
            if (bus.b_valid && bus.mem_ready) begin
                m_cnt_b <= m_cnt_b + 1;
                m_last  <= 2;
                m_owner <= bus.a_valid ? 1 : 0;
            end else if (!bus.b_valid) m_owner <= 0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        if (chk_en) begin
            logic        e_mv, e_in, e_ar, e_br;
            logic [31:0] e_ad, e_wd;
            logic [3:0]  e_ws;
            e_mv = 0; e_in = 0; e_ad = 0; e_wd = 0; e_ws = 0; e_ar = 0; e_br = 0;
            if (m_owner == 1) begin
                e_mv = bus.a_valid; e_in = bus.a_instr; e_ad = bus.a_addr;
                e_wd = bus.a_wdata; e_ws = bus.a_wstrb; e_ar = bus.a_valid & bus.mem_ready;
            end else if (m_owner == 2) begin
                e_mv = bus.b_valid; e_in = bus.b_instr; e_ad = bus.b_addr;
                e_wd = bus.b_wdata; e_ws = bus.b_wstrb; e_br = bus.b_valid & bus.mem_ready;
            end
            check("grant_a",   64'(bus.grant_a),   64'(m_owner == 1));
            check("grant_b",   64'(bus.grant_b),   64'(m_owner == 2));
            check("mem_valid", 64'(bus.mem_valid), 64'(e_mv));
            check("mem_instr", 64'(bus.mem_instr), 64'(e_in));
            check("mem_addr",  64'(bus.mem_addr),  64'(e_ad));
            check("mem_wdata", 64'(bus.mem_wdata), 64'(e_wd));
            check("mem_wstrb", 64'(bus.mem_wstrb), 64'(e_ws));
            check("a_ready",   64'(bus.a_ready),   64'(e_ar));
            check("b_ready",   64'(bus.b_ready),   64'(e_br));
            check("a_rdata",   64'(bus.a_rdata),   64'(bus.mem_rdata));
            check("b_rdata",   64'(bus.b_rdata),   64'(bus.mem_rdata));
            check("cnt_a",     64'(bus.cnt_a),     64'(m_cnt_a));
            check("cnt_b",     64'(bus.cnt_b),     64'(m_cnt_b));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.a_valid = 0; bus.a_instr = 0; bus.a_addr = 0; bus.a_wdata = 0; bus.a_wstrb = 0;
        bus.b_valid = 0; bus.b_instr = 0; bus.b_addr = 0; bus.b_wdata = 0; bus.b_wstrb = 0;
        bus.mem_ready = 0; bus.mem_rdata = 0;
        bus4.a_valid = 0; bus4.a_instr = 0; bus4.a_addr = 0; bus4.a_wdata = 0; bus4.a_wstrb = 0;
        bus4.b_valid = 0; bus4.b_instr = 0; bus4.b_addr = 0; bus4.b_wdata = 0; bus4.b_wstrb = 0;
        bus4.mem_ready = 0; bus4.mem_rdata = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        // ---- reset with both masters requesting ----
        bus.a_valid = 1; bus.a_addr = 32'h0000_0A00; bus.a_instr = 1;
        bus.b_valid = 1; bus.b_addr = 32'h0000_0B00;
        reset = 1;
        tick();
        chk_en = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            check("rst_mem_valid", 64'(bus.mem_valid), 64'd0);
            check("rst_grants", 64'({bus.grant_a, bus.grant_b}), 64'd0);
            check("rst_cnts", 64'({bus.cnt_a, bus.cnt_b}), 64'd0);
            check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
            if (i == 0) tick();
        end
        tick();
        reset = 0;
        tick();
        @(negedge clock);
        check("rel_grant_a", 64'(bus.grant_a), 64'd1);
        check("rel_mem_addr", 64'(bus.mem_addr), 64'h0A00);

        // ---- single master, slave waits 3 cycles ----
        do_reset();
        bus.a_valid = 1; bus.a_addr = 32'h100; bus.a_wstrb = 4'h0;
        tick();
        @(negedge clock);
        check("single_grant", 64'(bus.grant_a), 64'd1);
        check("single_addr", 64'(bus.mem_addr), 64'h100);
        tick(); tick();
        bus.mem_ready = 1; bus.mem_rdata = 32'hDEADBEEF;
        @(negedge clock);
        check("single_a_ready", 64'(bus.a_ready), 64'd1);
        check("single_a_rdata", 64'(bus.a_rdata), 64'hDEADBEEF);
        check("single_b_ready", 64'(bus.b_ready), 64'd0);
        tick();
        bus.a_valid = 0; bus.mem_ready = 0;
        @(negedge clock);
        check("single_cnt_a", 64'(bus.cnt_a), 64'd1);
        check("single_a_ready_off", 64'(bus.a_ready), 64'd0);

        // ---- contention: both always valid, slave always ready ----
        do_reset();
        bus.a_valid = 1; bus.a_addr = 32'h1000; bus.a_wdata = 32'h1111_2222; bus.a_wstrb = 4'hF;
        bus.b_valid = 1; bus.b_addr = 32'h2000; bus.b_instr = 1;
        bus.mem_ready = 1; bus.mem_rdata = 32'h5A5A_0001;
        tick();
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("alt_grant_a", 64'(bus.grant_a), 64'((i % 2) == 0));
            check("alt_grant_b", 64'(bus.grant_b), 64'((i % 2) == 1));
            tick();
        end
        bus.a_valid = 0; bus.b_valid = 0; bus.mem_ready = 0;
        @(negedge clock);
        check("alt_cnt_a", 64'(bus.cnt_a), 64'd5);
        check("alt_cnt_b", 64'(bus.cnt_b), 64'd5);
        tick();

        // ---- hold: B granted, slave stalls 5 cycles while A waits ----
        do_reset();
        bus.b_valid = 1; bus.b_addr = 32'h2000; bus.b_wdata = 32'hCAFE_0000; bus.b_wstrb = 4'h3;
        tick();
        bus.a_valid = 1; bus.a_addr = 32'h1000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("hold_grant_b", 64'(bus.grant_b), 64'd1);
            check("hold_addr", 64'(bus.mem_addr), 64'h2000);
            check("hold_a_ready", 64'(bus.a_ready), 64'd0);
            tick();
        end
        bus.mem_ready = 1; bus.mem_rdata = 32'h0BAD_F00D;
        @(negedge clock);
        check("hold_b_ready", 64'(bus.b_ready), 64'd1);
        tick();
        bus.b_valid = 0; bus.mem_ready = 0;
        @(negedge clock);
        check("hold_next_grant_a", 64'(bus.grant_a), 64'd1);
        check("hold_next_addr", 64'(bus.mem_addr), 64'h1000);
        check("hold_cnt_b", 64'(bus.cnt_b), 64'd1);
        bus.a_valid = 0;
        tick();

        // ---- abort: reset hits while A is granted, slave ready in the same cycle ----
        do_reset();
        bus.a_valid = 1; bus.a_addr = 32'h3000;
        tick();
        @(negedge clock);
        check("abort_grant_a", 64'(bus.grant_a), 64'd1);
        tick();
        reset = 1; bus.mem_ready = 1;
        tick();
        reset = 0; bus.mem_ready = 0; bus.a_valid = 0;
        @(negedge clock);
        check("abort_mem_valid", 64'(bus.mem_valid), 64'd0);
        check("abort_grant_a_off", 64'(bus.grant_a), 64'd0);
        check("abort_cnt_a", 64'(bus.cnt_a), 64'd0);
        tick();

        // ---- wrap on the 4-bit-counter instance: 16 then 17 A completions ----
        do_reset();
        bus4.a_valid = 1; bus4.a_addr = 32'h40; bus4.mem_ready = 1;
        repeat (32) tick();
        @(negedge clock);
        check("wrap16_cnt_a", 64'(bus4.cnt_a), 64'd0);
        check("wrap16_grant_a", 64'(bus4.grant_a), 64'd0);
        tick(); tick();
        bus4.a_valid = 0; bus4.mem_ready = 0;
        @(negedge clock);
        check("wrap17_cnt_a", 64'(bus4.cnt_a), 64'd1);
        check("wrap17_cnt_b", 64'(bus4.cnt_b), 64'd0);
        tick();

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
